// File: rtl/hazard_tracker.sv
// Hazard tracker: stall and forwarding-select generation from Tuse/Tnew
// records of the E/M/W instructions, plus the mult/div busy counter.
module hazard_tracker #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] D_Tuse1,
  input  logic [1:0] D_Tuse2,
  input  logic [4:0] D_ReadA1,
  input  logic [4:0] D_ReadA2,
  input  logic [1:0] D_Tnew,
  input  logic [4:0] D_WriteA,
  input  logic       D_IsMD,
  input  logic       E_MDStart,
  input  logic       E_MDIsDiv,
  input  logic       Flush,
  output logic       Stall,
  output logic [1:0] FwdD1,
  output logic [1:0] FwdD2,
  output logic [1:0] FwdE1,
  output logic [1:0] FwdE2,
  output logic       FwdM2,
  output logic       MDBusy
);

  localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CW0  = $clog2(MAXC + 1);
  localparam int CW   = (CW0 < 4) ? 4 : CW0;

  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYC);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYC);

  logic [4:0]    e_ra1;
  logic [4:0]    e_ra2;
  logic [4:0]    e_wa;
  logic [1:0]    e_tnew;
  logic [4:0]    m_ra2;
  logic [4:0]    m_wa;
  logic [1:0]    m_tnew;
  logic [4:0]    w_wa;
  logic [CW-1:0] md_cnt;

  function automatic logic [1:0] dec_sat(
    input logic [1:0] t
  );
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // A younger producer still computing blocks older forwards.
  function automatic logic [1:0] fwd_d(
    input logic [4:0] ra,
    input logic [4:0] ew,
    input logic [1:0] et,
    input logic [4:0] mw,
    input logic [1:0] mt,
    input logic [4:0] ww
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (ra == 5'd0)
      sel = 2'd0;
    else if (ew == ra)
      sel = (et == 2'd0) ? 2'd1 : 2'd0;
    else if (mw == ra)
      sel = (mt == 2'd0) ? 2'd2 : 2'd0;
    else if (ww == ra)
      sel = 2'd3;
    return sel;
  endfunction

  function automatic logic [1:0] fwd_e(
    input logic [4:0] ra,
    input logic [4:0] mw,
    input logic [1:0] mt,
    input logic [4:0] ww
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (ra == 5'd0)
      sel = 2'd0;
    else if (mw == ra && mt == 2'd0)
      sel = 2'd2;
    else if (ww == ra)
      sel = 2'd3;
    return sel;
  endfunction

  function automatic logic gpr_hz(
    input logic [4:0] ra,
    input logic [1:0] tuse,
    input logic [4:0] ew,
    input logic [1:0] et,
    input logic [4:0] mw,
    input logic [1:0] mt
  );
    logic h;
    h = 1'b0;
    if (ra != 5'd0) begin
      if (ew == ra && et > tuse)
        h = 1'b1;
      if (mw == ra && mt > tuse)
        h = 1'b1;
    end
    return h;
  endfunction

  logic hz1;
  logic hz2;
  logic md_hz;

  always_comb begin
    MDBusy = (md_cnt != '0) | E_MDStart;
    hz1    = gpr_hz(D_ReadA1, D_Tuse1,
                    e_wa, e_tnew, m_wa, m_tnew);
    hz2    = gpr_hz(D_ReadA2, D_Tuse2,
                    e_wa, e_tnew, m_wa, m_tnew);
    md_hz  = D_IsMD & MDBusy;
    Stall  = hz1 | hz2 | md_hz;
  end

  always_comb begin
    FwdD1 = fwd_d(D_ReadA1, e_wa, e_tnew,
                  m_wa, m_tnew, w_wa);
    FwdD2 = fwd_d(D_ReadA2, e_wa, e_tnew,
                  m_wa, m_tnew, w_wa);
    FwdE1 = fwd_e(e_ra1, m_wa, m_tnew, w_wa);
    FwdE2 = fwd_e(e_ra2, m_wa, m_tnew, w_wa);
    FwdM2 = (m_ra2 != 5'd0) && (w_wa == m_ra2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_ra1  <= '0;
      e_ra2  <= '0;
      e_wa   <= '0;
      e_tnew <= '0;
      m_ra2  <= '0;
      m_wa   <= '0;
      m_tnew <= '0;
      w_wa   <= '0;
    end else if (Flush) begin
      e_ra1  <= '0;
      e_ra2  <= '0;
      e_wa   <= '0;
      e_tnew <= '0;
      m_ra2  <= '0;
      m_wa   <= '0;
      m_tnew <= '0;
      w_wa   <= '0;
    end else begin
      w_wa   <= m_wa;
      m_ra2  <= e_ra2;
      m_wa   <= e_wa;
      m_tnew <= dec_sat(e_tnew);
      if (Stall) begin
        e_ra1  <= '0;
        e_ra2  <= '0;
        e_wa   <= '0;
        e_tnew <= '0;
      end else begin
        e_ra1  <= D_ReadA1;
        e_ra2  <= D_ReadA2;
        e_wa   <= D_WriteA;
        e_tnew <= dec_sat(D_Tnew);
      end
    end
  end

  // Flush leaves an in-flight mult/div running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      md_cnt <= '0;
    else if (E_MDStart)
      md_cnt <= E_MDIsDiv ? DIV_LD : MULT_LD;
    else if (md_cnt != '0)
      md_cnt <= md_cnt - CW'(1);
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Scenario bench for hazard_tracker: per-cycle expected outputs are
// queued as stimulus is applied and compared before the next edge.
module tb_hazard_tracker;

  typedef struct packed {
    logic [1:0] tu1;
    logic [1:0] tu2;
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic [1:0] tn;
    logic [4:0] wa;
    logic       md;
    logic       st;
    logic       dv;
    logic       fl;
  } stim_t;

  logic       clk;
  logic       reset;
  logic [1:0] D_Tuse1;
  logic [1:0] D_Tuse2;
  logic [4:0] D_ReadA1;
  logic [4:0] D_ReadA2;
  logic [1:0] D_Tnew;
  logic [4:0] D_WriteA;
  logic       D_IsMD;
  logic       E_MDStart;
  logic       E_MDIsDiv;
  logic       Flush;
  logic       Stall;
  logic [1:0] FwdD1;
  logic [1:0] FwdD2;
  logic [1:0] FwdE1;
  logic [1:0] FwdE2;
  logic       FwdM2;
  logic       MDBusy;

  logic [10:0] obs;
  logic [10:0] exq[$];
  int total;
  int bad;

  hazard_tracker #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset),
    .D_Tuse1(D_Tuse1), .D_Tuse2(D_Tuse2),
    .D_ReadA1(D_ReadA1), .D_ReadA2(D_ReadA2),
    .D_Tnew(D_Tnew), .D_WriteA(D_WriteA),
    .D_IsMD(D_IsMD), .E_MDStart(E_MDStart),
    .E_MDIsDiv(E_MDIsDiv), .Flush(Flush),
    .Stall(Stall), .FwdD1(FwdD1), .FwdD2(FwdD2),
    .FwdE1(FwdE1), .FwdE2(FwdE2),
    .FwdM2(FwdM2), .MDBusy(MDBusy)
  );

  assign obs = {Stall, FwdD1, FwdD2, FwdE1,
                FwdE2, FwdM2, MDBusy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t ins(
    input logic [1:0] tu1, input logic [1:0] tu2,
    input logic [4:0] ra1, input logic [4:0] ra2,
    input logic [1:0] tn,  input logic [4:0] wa,
    input logic md = 1'b0, input logic st = 1'b0,
    input logic dv = 1'b0, input logic fl = 1'b0
  );
    return '{tu1, tu2, ra1, ra2, tn, wa,
             md, st, dv, fl};
  endfunction

  function automatic logic [10:0] ex(
    input logic st, input logic [1:0] d1,
    input logic [1:0] d2, input logic [1:0] e1,
    input logic [1:0] e2, input logic m2,
    input logic b
  );
    return {st, d1, d2, e1, e2, m2, b};
  endfunction

  task automatic apply(input stim_t x);
    D_Tuse1   = x.tu1;
    D_Tuse2   = x.tu2;
    D_ReadA1  = x.ra1;
    D_ReadA2  = x.ra2;
    D_Tnew    = x.tn;
    D_WriteA  = x.wa;
    D_IsMD    = x.md;
    E_MDStart = x.st;
    E_MDIsDiv = x.dv;
    Flush     = x.fl;
  endtask

  task automatic do_reset();
    apply(ins(0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] want;
    apply(ins(0, 0, 5, 6, 3, 5, 1'b1));
    reset = 1'b1;
    @(negedge clk);
    exq.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    #2;
    want = exq.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL reset got=%b want=%b", obs, want);
    end
    do_reset();
  endtask

  task automatic test_alu_fwd();
    stim_t s[$];
    logic [10:0] e[$];
    logic [10:0] want;
    do_reset();
    s.push_back(ins(1, 1, 1, 2, 2, 3));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(1, 1, 3, 4, 2, 6));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(1, 1, 0, 3, 2, 0));
    e.push_back(ex(0, 0, 2, 2, 0, 0, 0));
    s.push_back(ins(1, 1, 3, 0, 0, 0));
    e.push_back(ex(0, 3, 0, 0, 3, 0, 0));
    s.push_back(ins(0, 0, 0, 0, 0, 0));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clk);
      apply(s[i]);
      exq.push_back(e[i]);
      #2;
      want = exq.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL alu_fwd[%0d] got=%b want=%b",
                 i, obs, want);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t s[$];
    logic [10:0] e[$];
    logic [10:0] want;
    do_reset();
    s.push_back(ins(0, 0, 1, 0, 3, 5));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 5, 6, 0, 0));
    e.push_back(ex(1, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 5, 6, 0, 0));
    e.push_back(ex(1, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 5, 6, 0, 0));
    e.push_back(ex(0, 3, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 0, 0, 0, 0));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clk);
      apply(s[i]);
      exq.push_back(e[i]);
      #2;
      want = exq.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL load_use[%0d] got=%b want=%b",
                 i, obs, want);
      end
    end
  endtask

  task automatic test_jal_jr();
    stim_t s[$];
    logic [10:0] e[$];
    logic [10:0] want;
    do_reset();
    s.push_back(ins(0, 0, 0, 0, 1, 31));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 31, 0, 0, 0));
    e.push_back(ex(0, 1, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 0, 0, 0, 0));
    e.push_back(ex(0, 0, 0, 2, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clk);
      apply(s[i]);
      exq.push_back(e[i]);
      #2;
      want = exq.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL jal_jr[%0d] got=%b want=%b",
                 i, obs, want);
      end
    end
  endtask

  task automatic test_store_data();
    stim_t s[$];
    logic [10:0] e[$];
    logic [10:0] want;
    do_reset();
    s.push_back(ins(0, 0, 2, 0, 3, 7));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(1, 2, 2, 7, 0, 0));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 0, 0, 0, 0));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 0, 0, 0, 0));
    e.push_back(ex(0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clk);
      apply(s[i]);
      exq.push_back(e[i]);
      #2;
      want = exq.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL store[%0d] got=%b want=%b",
                 i, obs, want);
      end
    end
  endtask

  task automatic test_boundary();
    stim_t s[$];
    logic [10:0] e[$];
    logic [10:0] want;
    do_reset();
    s.push_back(ins(0, 0, 0, 0, 3, 7));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(1, 1, 0, 7, 1, 0));
    e.push_back(ex(1, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(1, 1, 0, 7, 1, 0));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 0, 0, 0, 0));
    e.push_back(ex(0, 0, 0, 0, 3, 0, 0));
    s.push_back(ins(0, 0, 0, 0, 1, 8));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 0, 0, 1, 8));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 8, 0, 0, 0));
    e.push_back(ex(0, 1, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 0, 0, 1, 9));
    e.push_back(ex(0, 0, 0, 2, 0, 0, 0));
    s.push_back(ins(0, 0, 0, 0, 3, 9));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 9, 0, 0, 0));
    e.push_back(ex(1, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 9, 0, 0, 0));
    e.push_back(ex(1, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 9, 0, 0, 0));
    e.push_back(ex(0, 3, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 0, 0, 3, 0));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 0, 0, 0, 0));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clk);
      apply(s[i]);
      exq.push_back(e[i]);
      #2;
      want = exq.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL boundary[%0d] got=%b want=%b",
                 i, obs, want);
      end
    end
  endtask

  task automatic test_muldiv();
    stim_t s[$];
    logic [10:0] e[$];
    logic [10:0] want;
    do_reset();
    s.push_back(ins(0, 0, 0, 0, 2, 4, 1, 1, 1));
    e.push_back(ex(1, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 10; k++) begin
      s.push_back(ins(0, 0, 0, 0, 2, 4, 1));
      e.push_back(ex(1, 0, 0, 0, 0, 0, 1));
    end
    s.push_back(ins(0, 0, 0, 0, 2, 4, 1));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 0, 0, 0, 0, 0, 1, 0));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 5; k++) begin
      s.push_back(ins(0, 0, 0, 0, 0, 0));
      e.push_back(ex(0, 0, 0, 0, 0, 0, 1));
    end
    s.push_back(ins(0, 0, 0, 0, 0, 0));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clk);
      apply(s[i]);
      exq.push_back(e[i]);
      #2;
      want = exq.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL muldiv[%0d] got=%b want=%b",
                 i, obs, want);
      end
    end
  endtask

  task automatic test_flush();
    stim_t s[$];
    logic [10:0] e[$];
    logic [10:0] want;
    do_reset();
    s.push_back(ins(0, 0, 1, 0, 3, 5));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 1, 0, 3, 6));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    s.push_back(ins(0, 0, 5, 6, 0, 0, 0, 1, 0, 1));
    e.push_back(ex(1, 0, 0, 0, 0, 0, 1));
    s.push_back(ins(0, 0, 5, 6, 0, 0));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clk);
      apply(s[i]);
      exq.push_back(e[i]);
      #2;
      want = exq.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL flush[%0d] got=%b want=%b",
                 i, obs, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[$];
    logic [10:0] e[$];
    logic [10:0] want;
    do_reset();
    s.push_back(ins(0, 0, 1, 0, 3, 5, 0, 1, 1));
    e.push_back(ex(0, 0, 0, 0, 0, 0, 1));
    s.push_back(ins(0, 0, 5, 0, 0, 0));
    e.push_back(ex(1, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clk);
      apply(s[i]);
      exq.push_back(e[i]);
      #2;
      want = exq.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL reset_mid[%0d] got=%b want=%b",
                 i, obs, want);
      end
    end
    #1;
    reset = 1'b1;
    exq.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    #1;
    want = exq.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL reset_async got=%b want=%b",
               obs, want);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exq.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    #2;
    want = exq.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL reset_after got=%b want=%b",
               obs, want);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    apply(ins(0, 0, 0, 0, 0, 0));
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_jal_jr();
    test_store_data();
    test_boundary();
    test_muldiv();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
